// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from execute, issues a single
// aligned 64-bit memory command, and returns lane-shifted, extended load data
// (or a completion for stores) to writeback. An access that waits too long
// for memory is aborted with resp_err.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject accesses whose
// address is not a multiple of the access size, without touching memory.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_wdt_op,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // Width code: 0 byte, 1 half, 2 word, 3 double; anything not one-hot is double.
    function automatic logic [1:0] size_code(input logic [3:0] op);
        case (op)
            4'b0001: size_code = 2'd0;
            4'b0010: size_code = 2'd1;
            4'b0100: size_code = 2'd2;
            default: size_code = 2'd3;
        endcase
    endfunction

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wait_count;
    logic            wen_q;
    logic [63:0]     addr_q;
    logic [63:0]     wdata_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [63:0]     rdata_q;
    logic            err_q;

    logic [2:0]      offset;
    logic            timeout_hit;
    logic [7:0]      base_mask;
    logic [7:0]      lane_mask;
    logic [63:0]     lane_wdata;
    logic [63:0]     shifted_rdata;
    logic [63:0]     load_data;

`ifdef LSU_MISALIGN_CHECK_EN
    logic            misaligned;
    logic [2:0]      align_mask;

    // Low address bits that must be zero for the incoming access size.
    always_comb begin
        case (size_code(req_wdt_op))
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned = |(req_addr[2:0] & align_mask);
    end
`endif

    assign offset      = addr_q[2:0];
    assign timeout_hit = (wait_count >= CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; memory responses outside WAIT are deliberately ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_CHECK_EN
                    next_state = misaligned ? RESP : REQ;
`else
                    next_state = REQ;
`endif
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // WAIT cycle counter: zero outside WAIT so each entry starts fresh; saturates.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wait_count <= '0;
        end else if (wait_count < CW'(TIMEOUT)) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    // Lane steering for stores and extraction/extension for loads.
    always_comb begin
        case (size_q)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        lane_mask     = base_mask << offset;
        lane_wdata    = wdata_q << {offset, 3'b000};
        shifted_rdata = mem_rdata >> {offset, 3'b000};
        case (size_q)
            2'd0:    load_data = unsigned_q ? {56'd0, shifted_rdata[7:0]}
                                            : {{56{shifted_rdata[7]}}, shifted_rdata[7:0]};
            2'd1:    load_data = unsigned_q ? {48'd0, shifted_rdata[15:0]}
                                            : {{48{shifted_rdata[15]}}, shifted_rdata[15:0]};
            2'd2:    load_data = unsigned_q ? {32'd0, shifted_rdata[31:0]}
                                            : {{32{shifted_rdata[31]}}, shifted_rdata[31:0]};
            default: load_data = shifted_rdata;
        endcase
    end

    // Command latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q      <= req_wen;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= size_code(req_wdt_op);
                        unsigned_q <= req_unsigned;
                        rdata_q    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                        err_q      <= misaligned;
`else
                        err_q      <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= wen_q ? 64'd0 : load_data;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign resp_valid    = (state == RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = {addr_q[63:3], 3'b000};
    assign mem_wen       = (state == REQ) && wen_q;
    assign mem_wdata     = mem_wen ? lane_wdata : 64'd0;
    assign mem_wmask     = mem_wen ? lane_mask : 8'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT = 255).
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWen;
    logic [63:0] reqAddr;
    logic [63:0] reqWdata;
    logic [3:0]  reqWdtOp;
    logic        reqUnsigned;
    logic        respValid;
    logic        respReady;
    logic [63:0] respRdata;
    logic        respErr;
    logic        memReqValid;
    logic        memReqReady;
    logic [63:0] memAddr;
    logic        memWen;
    logic [63:0] memWdata;
    logic [7:0]  memWmask;
    logic        memRvalid;
    logic [63:0] memRdata;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;
    int edges;

    load_store_unit #(.TIMEOUT(255)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (reqValid),
        .req_ready     (reqReady),
        .req_wen       (reqWen),
        .req_addr      (reqAddr),
        .req_wdata     (reqWdata),
        .req_wdt_op    (reqWdtOp),
        .req_unsigned  (reqUnsigned),
        .resp_valid    (respValid),
        .resp_ready    (respReady),
        .resp_rdata    (respRdata),
        .resp_err      (respErr),
        .mem_req_valid (memReqValid),
        .mem_req_ready (memReqReady),
        .mem_addr      (memAddr),
        .mem_wen       (memWen),
        .mem_wdata     (memWdata),
        .mem_wmask     (memWmask),
        .mem_rvalid    (memRvalid),
        .mem_rdata     (memRdata),
        .busy          (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic wen, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [3:0] wdt,
                                 input logic uns);
        reqValid    = valid;
        reqWen      = wen;
        reqAddr     = addr;
        reqWdata    = wdata;
        reqWdtOp    = wdt;
        reqUnsigned = uns;
    endtask

    task automatic idleRequest();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic memAccept();
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
    endtask

    task automatic memRespond(input logic [63:0] data);
        memRvalid = 1'b1;
        memRdata  = data;
        tick();
        memRvalid = 1'b0;
        memRdata  = 64'd0;
    endtask

    task automatic finishResp(input string tag);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        checkOutput(tag, 64'(respValid), 64'd0);
        checkOutput({tag, "_ready"}, 64'(reqReady), 64'd1);
    endtask

    initial begin
        rst         = 1'b1;
        idleRequest();
        respReady   = 1'b0;
        memReqReady = 1'b0;
        memRvalid   = 1'b0;
        memRdata    = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("rst_req_ready", 64'(reqReady), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
        checkOutput("rst_resp_err", 64'(respErr), 64'd0);
        checkOutput("rst_resp_rdata", respRdata, 64'd0);
        checkOutput("rst_mem_req_valid", 64'(memReqValid), 64'd0);
        checkOutput("rst_mem_wen", 64'(memWen), 64'd0);
        checkOutput("rst_mem_wmask", 64'(memWmask), 64'd0);
        checkOutput("rst_mem_addr", memAddr, 64'd0);
        checkOutput("rst_mem_wdata", memWdata, 64'd0);

        // Signed byte load at offset 3, zero-wait memory
        applyStimulus(1'b1, 1'b0, 64'h80000003, 64'd0, 4'b0001, 1'b0);
        tick();
        idleRequest();
        checkOutput("lb_req_valid", 64'(memReqValid), 64'd1);
        checkOutput("lb_mem_addr", memAddr, 64'h80000000);
        checkOutput("lb_mem_wmask", 64'(memWmask), 64'd0);
        checkOutput("lb_busy", 64'(busy), 64'd1);
        checkOutput("lb_req_ready", 64'(reqReady), 64'd0);
        memAccept();
        checkOutput("lb_wait_req_valid", 64'(memReqValid), 64'd0);
        memRespond(64'h00000000_80000000);
        checkOutput("lb_resp_valid", 64'(respValid), 64'd1);
        checkOutput("lb_rdata", respRdata, 64'hFFFFFFFF_FFFFFF80);
        checkOutput("lb_err", 64'(respErr), 64'd0);
        finishResp("lb_done");

        // Half store at offset 6
        applyStimulus(1'b1, 1'b1, 64'h80000006, 64'h1234, 4'b0010, 1'b0);
        tick();
        idleRequest();
        checkOutput("sh_mem_addr", memAddr, 64'h80000000);
        checkOutput("sh_mem_wen", 64'(memWen), 64'd1);
        checkOutput("sh_mem_wmask", 64'(memWmask), 64'hC0);
        checkOutput("sh_mem_wdata", memWdata, 64'h12340000_00000000);
        memAccept();
        memRespond(64'hDEADBEEF_DEADBEEF);
        checkOutput("sh_resp_valid", 64'(respValid), 64'd1);
        checkOutput("sh_rdata", respRdata, 64'd0);
        checkOutput("sh_err", 64'(respErr), 64'd0);
        finishResp("sh_done");

        // Unsigned half load with command stall, slow data and held response
        applyStimulus(1'b1, 1'b0, 64'h80000004, 64'd0, 4'b0010, 1'b1);
        tick();
        idleRequest();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                memRvalid = 1'b1;
                memRdata  = 64'hFFFFFFFF_FFFFFFFF;
            end
            checkOutput("stall_req_valid", 64'(memReqValid), 64'd1);
            tick();
            memRvalid = 1'b0;
            memRdata  = 64'd0;
        end
        checkOutput("stall_still_req", 64'(memReqValid), 64'd1);
        memAccept();
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_wait_no_resp", 64'(respValid), 64'd0);
            tick();
        end
        checkOutput("stall_wait_no_resp2", 64'(respValid), 64'd0);
        memRespond(64'h0000ABCD_00000000);
        applyStimulus(1'b1, 1'b0, 64'h80000000, 64'd0, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_resp_valid", 64'(respValid), 64'd1);
            checkOutput("hold_rdata", respRdata, 64'h00000000_0000ABCD);
            checkOutput("hold_req_ready", 64'(reqReady), 64'd0);
            tick();
        end
        finishResp("hold_done");

        // The request held during RESP is accepted now: signed word load
        tick();
        idleRequest();
        checkOutput("lw_req_valid", 64'(memReqValid), 64'd1);
        checkOutput("lw_mem_addr", memAddr, 64'h80000000);
        checkOutput("lw_mem_wen", 64'(memWen), 64'd0);
        memAccept();
        memRespond(64'h11112222_87654321);
        checkOutput("lw_rdata", respRdata, 64'hFFFFFFFF_87654321);
        finishResp("lw_done");

        // Non-one-hot width store behaves as double
        applyStimulus(1'b1, 1'b1, 64'h80000010, 64'hCAFEBABE_12345678, 4'b0110, 1'b0);
        tick();
        idleRequest();
        checkOutput("sd_mem_addr", memAddr, 64'h80000010);
        checkOutput("sd_mem_wmask", 64'(memWmask), 64'hFF);
        checkOutput("sd_mem_wdata", memWdata, 64'hCAFEBABE_12345678);
        memAccept();
        memRespond(64'h5555);
        checkOutput("sd_rdata", respRdata, 64'd0);
        finishResp("sd_done");

        // Byte store in the top lane drops upper store data
        applyStimulus(1'b1, 1'b1, 64'h80000007, 64'h12345678_9ABCDEAB, 4'b0001, 1'b0);
        tick();
        idleRequest();
        checkOutput("sb_mem_wmask", 64'(memWmask), 64'h80);
        checkOutput("sb_mem_wdata", memWdata, 64'hAB000000_00000000);
        memAccept();
        memRespond(64'd0);
        finishResp("sb_done");

        // Double load keeps all bits, no extension applied
        applyStimulus(1'b1, 1'b0, 64'h80000008, 64'd0, 4'b1000, 1'b1);
        tick();
        idleRequest();
        checkOutput("ld_mem_addr", memAddr, 64'h80000008);
        memAccept();
        memRespond(64'h80000000_00000001);
        checkOutput("ld_rdata", respRdata, 64'h80000000_00000001);
        finishResp("ld_done");

        // Misaligned word load at offset 2
        applyStimulus(1'b1, 1'b0, 64'h80000002, 64'd0, 4'b0100, 1'b0);
        tick();
        idleRequest();
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("mis_resp_valid", 64'(respValid), 64'd1);
        checkOutput("mis_err", 64'(respErr), 64'd1);
        checkOutput("mis_rdata", respRdata, 64'd0);
        checkOutput("mis_no_mem_req", 64'(memReqValid), 64'd0);
`else
        checkOutput("mis_mem_req_valid", 64'(memReqValid), 64'd1);
        checkOutput("mis_mem_addr", memAddr, 64'h80000000);
        memAccept();
        memRespond(64'hAABBCCDD_EEFF0011);
        checkOutput("mis_resp_valid", 64'(respValid), 64'd1);
        checkOutput("mis_err", 64'(respErr), 64'd0);
        checkOutput("mis_rdata", respRdata, 64'hFFFFFFFF_CCDDEEFF);
`endif
        finishResp("mis_done");

        // Timeout: memory never answers
        applyStimulus(1'b1, 1'b0, 64'h80000000, 64'd0, 4'b1000, 1'b0);
        tick();
        idleRequest();
        memAccept();
        edges = 0;
        while (!respValid && edges < 400) begin
            tick();
            edges++;
        end
        checkOutput("to_wait_cycles", 64'(edges), 64'd255);
        checkOutput("to_resp_valid", 64'(respValid), 64'd1);
        checkOutput("to_err", 64'(respErr), 64'd1);
        checkOutput("to_rdata", respRdata, 64'd0);
        finishResp("to_done");

        // Reset during WAIT, late memory response afterwards
        applyStimulus(1'b1, 1'b0, 64'h80000000, 64'd0, 4'b1000, 1'b0);
        tick();
        idleRequest();
        memAccept();
        checkOutput("rw_in_wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        memRvalid = 1'b1;
        memRdata  = 64'h12345678_12345678;
        checkOutput("rw_req_ready", 64'(reqReady), 64'd1);
        checkOutput("rw_busy", 64'(busy), 64'd0);
        checkOutput("rw_resp_valid", 64'(respValid), 64'd0);
        tick();
        memRvalid = 1'b0;
        memRdata  = 64'd0;
        checkOutput("rw_late_resp_valid", 64'(respValid), 64'd0);
        checkOutput("rw_late_req_ready", 64'(reqReady), 64'd1);
        checkOutput("rw_late_mem_req", 64'(memReqValid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum cycles spent in WAIT before the access is aborted with an error.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  execute stage presents a load or store.
REQ-005 req_ready  output  1  unit accepts a request (high only in IDLE).
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  64  byte address (alu_result).
REQ-008 req_wdata  input  64  store data, right-aligned (rs2 value).
REQ-009 req_wdt_op  input  4  one-hot width {double[3], word[2], half[1], byte[0]}.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid / resp_ready  output / input  1 / 1  completion handshake to writeback.
REQ-012 resp_rdata  output  64  lane-shifted, extended load data; 0 for stores.
REQ-013 resp_err  output  1  access aborted (timeout, or misalignment when enabled).
REQ-014 mem_req_valid / mem_req_ready  output / input  1 / 1  memory command handshake.
REQ-015 mem_addr  output  64  req_addr with bits [2:0] cleared.
REQ-016 mem_wen, mem_wdata, mem_wmask  output  1, 64, 8  store enable, lane-shifted data, byte strobes.
REQ-017 mem_rvalid / mem_rdata  input  1 / 64  memory response; mem_rvalid acknowledges both loads and stores.
REQ-018 busy  output  1  high in any state except IDLE; used by the pipeline to stall PC and IF_ID.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, RESP.
REQ-020 IDLE: req_ready=1. req_valid latches all req_* fields; next state REQ.
REQ-021 REQ: mem_req_valid=1 with the latched command. mem_req_ready moves the FSM to WAIT. mem_rvalid is ignored in REQ.
REQ-022 WAIT: mem_rvalid captures mem_rdata and moves the FSM to RESP with resp_err=0. A cycle counter that reaches TIMEOUT moves the FSM to RESP with resp_err=1 and resp_rdata=0.
REQ-023 RESP: resp_valid=1. Outputs hold stable until resp_ready; next state IDLE. The next request is accepted no earlier than the following cycle.
REQ-024 Minimum latency with zero-wait memory: request accepted in cycle N, resp_valid in cycle N+3.
REQ-025 Byte mask = {0xFF, 0x0F, 0x03, 0x01} for {d, w, h, b}, shifted left by addr[2:0]. Bits beyond lane 7 are dropped.
REQ-026 mem_wdata = req_wdata << (8*addr[2:0]); mem_wmask=0 and mem_wdata=0 on loads.
REQ-027 Load data = mem_rdata >> (8*addr[2:0]), truncated to the access width, then extended per req_unsigned. req_unsigned is ignored for double.
REQ-028 A non-one-hot req_wdt_op is treated as double.
REQ-029 The timeout counter clears on every entry to WAIT. It never wraps.

Reset
REQ-030 rst in any state forces IDLE on the next edge and clears the counter and latched fields.
REQ-031 After rst: resp_valid, resp_err, mem_req_valid, mem_wen, mem_wmask and busy are 0; resp_rdata and mem_* data are 0; req_ready=1.
REQ-032 A transaction interrupted by rst is abandoned without a response. A late mem_rvalid arriving in IDLE is ignored.

Configuration
REQ-033 Macro LSU_MISALIGN_CHECK_EN is defined: an address not a multiple of the access size skips REQ and WAIT and goes IDLE->RESP. No memory transaction is issued; resp_err=1 and resp_rdata=0. resp_valid appears at N+1.
REQ-034 Macro not defined: no misalignment check; misaligned accesses proceed per REQ-025/027, with truncation inside the 8-byte word.

Verification
REQ-035 Load byte signed at addr 0x80000003, mem_rdata 0x00000000_80000000 arriving immediately -> resp_rdata 0xFFFFFFFF_FFFFFF80 at N+3, resp_err=0.
REQ-036 Store half at 0x80000006, wdata 0x1234 -> mem_addr 0x80000000, mem_wmask 0xC0, mem_wdata 0x12340000_00000000, resp_rdata 0.
REQ-037 mem_req_ready held low 5 cycles, then mem_rvalid after 3 more -> single resp_valid. resp_valid held while resp_ready=0, and no new req_ready until the handshake completes.
REQ-038 mem_rvalid never asserted, TIMEOUT=255 -> resp_valid with resp_err=1 after 255 WAIT cycles.
REQ-039 rst asserted during WAIT, then mem_rvalid one cycle later -> IDLE, no resp_valid, req_ready=1.
REQ-040 Load word at 0x80000002: with LSU_MISALIGN_CHECK_EN -> resp_err=1 at N+1 and no mem_req_valid; without it -> mem_req_valid issued, resp_err=0.
